// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and operation-decode helpers for the iterative
// multiply/divide unit.
//   op_t    : RV32M/RV64M funct3 codes
//   state_t : control FSM states
//   is_div / is_rem / is_signed_a / is_signed_b : operation classification
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIX,
        ST_DONE
    } state_t;

    function automatic logic is_div(op_t op);
        return (op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU});
    endfunction

    function automatic logic is_rem(op_t op);
        return (op inside {OP_REM, OP_REMU});
    endfunction

    // Operand A is treated as two's complement for these operations
    function automatic logic is_signed_a(op_t op);
        return (op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
    endfunction

    // Operand B is treated as two's complement for these operations
    function automatic logic is_signed_b(op_t op);
        return (op inside {OP_MULH, OP_DIV, OP_REM});
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: request/response bundle of the multiply/divide unit.
//   I_flush                          : abandon the operation in flight
//   I_in_valid / O_in_ready          : request handshake
//   I_op, I_operandA, I_operandB     : funct3 code and rs1/rs2 values
//   O_out_valid / I_out_ready        : response handshake
//   O_result                         : registered result
// master = issuing stage, slave = muldiv_unit.
interface muldiv_if #(
    parameter int XLEN = 32
);
    logic            I_flush;
    logic            I_in_valid;
    logic            O_in_ready;
    logic [2:0]      I_op;
    logic [XLEN-1:0] I_operandA;
    logic [XLEN-1:0] I_operandB;
    logic            O_out_valid;
    logic            I_out_ready;
    logic [XLEN-1:0] O_result;

    modport master (
        output I_flush, I_in_valid, I_op, I_operandA, I_operandB, I_out_ready,
        input  O_in_ready, O_out_valid, O_result
    );

    modport slave (
        input  I_flush, I_in_valid, I_op, I_operandA, I_operandB, I_out_ready,
        output O_in_ready, O_out_valid, O_result
    );
endinterface

// File: rtl/muldiv_iter_core.sv
// muldiv_iter_core: one radix-2 iteration of the shared {hi,lo} datapath.
// Purely combinational.
//   is_div       : 1 = restoring-divide step, 0 = shift-add multiply step
//   hi_in/lo_in  : current {hi,lo} pair (multiply: partial product high half /
//                  multiplier bits; divide: partial remainder / quotient)
//   b_in         : multiplicand or divisor magnitude
//   hi_out/lo_out: {hi,lo} after the step
module muldiv_iter_core #(
    parameter int XLEN = 32
) (
    input  logic            is_div,
    input  logic [XLEN-1:0] hi_in,
    input  logic [XLEN-1:0] lo_in,
    input  logic [XLEN-1:0] b_in,
    output logic [XLEN-1:0] hi_out,
    output logic [XLEN-1:0] lo_out
);

    logic [XLEN:0]   sum;
    logic [XLEN:0]   shifted;
    logic [XLEN-1:0] diff;
    logic            borrow;

    always_comb begin
        // Multiply: conditionally add, then shift {carry,hi,lo} right by one.
        sum = {1'b0, hi_in} + (lo_in[0] ? {1'b0, b_in} : {(XLEN+1){1'b0}});

        // Divide: shift {rem,quot} left, trial-subtract the divisor. The
        // shifted remainder is below 2*divisor, so when it does not borrow the
        // difference fits in XLEN bits and the low bits of the wrap-around
        // subtraction are exact.
        shifted = {hi_in, lo_in[XLEN-1]};
        diff    = shifted[XLEN-1:0] - b_in;
        borrow  = !shifted[XLEN] && (shifted[XLEN-1:0] < b_in);

        if (is_div) begin
            hi_out = borrow ? shifted[XLEN-1:0] : diff;
            lo_out = {lo_in[XLEN-2:0], !borrow};
        end else begin
            hi_out = sum[XLEN:1];
            lo_out = {sum[0], lo_in[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M/RV64M multiply/divide unit.
//   I_clk   : rising-edge clock
//   I_rst_n : synchronous active-low reset
//   bus     : muldiv_if slave (flush, request and response handshakes)
// Normal ops take XLEN CALC cycles plus one FIX cycle; divide-by-zero and
// signed overflow go straight to DONE with the result from the raw operands.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic     I_clk,
    input  logic     I_rst_n,
    muldiv_if.slave  bus
);

    localparam int              CNT_W   = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state_reg,  state_next;
    logic [CNT_W-1:0]  cnt_reg,    cnt_next;
    logic [XLEN-1:0]   hi_reg,     hi_next;
    logic [XLEN-1:0]   lo_reg,     lo_next;
    logic [XLEN-1:0]   b_mag_reg,  b_mag_next;
    op_t               op_reg,     op_next;
    logic              sign_a_reg, sign_a_next;
    logic              sign_b_reg, sign_b_next;
    logic [XLEN-1:0]   result_reg, result_next;

    logic [XLEN-1:0]   core_hi, core_lo;

    // Incoming request decode
    op_t               op_in;
    logic              neg_a, neg_b, div_zero, overflow, accept;
    logic [XLEN-1:0]   a_mag, b_mag, special_result;

    // FIX-stage sign correction and selection
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix, rem_fix, fix_result;

    assign bus.O_in_ready  = (state_reg == ST_IDLE) && I_rst_n;
    assign bus.O_out_valid = (state_reg == ST_DONE);
    assign bus.O_result    = result_reg;

    muldiv_iter_core #(.XLEN(XLEN)) u_core (
        .is_div (is_div(op_reg)),
        .hi_in  (hi_reg),
        .lo_in  (lo_reg),
        .b_in   (b_mag_reg),
        .hi_out (core_hi),
        .lo_out (core_lo)
    );

    always_comb begin
        op_in    = op_t'(bus.I_op);
        neg_a    = is_signed_a(op_in) && bus.I_operandA[XLEN-1];
        neg_b    = is_signed_b(op_in) && bus.I_operandB[XLEN-1];
        // The most negative value negates to itself, which read as unsigned
        // is exactly its magnitude.
        a_mag    = neg_a ? -bus.I_operandA : bus.I_operandA;
        b_mag    = neg_b ? -bus.I_operandB : bus.I_operandB;
        div_zero = is_div(op_in) && (bus.I_operandB == '0);
        overflow = (op_in inside {OP_DIV, OP_REM}) &&
                   (bus.I_operandA == MIN_NEG) && (bus.I_operandB == '1);
        accept   = bus.I_in_valid && bus.O_in_ready;

        special_result = '0;
        if (div_zero) begin
            special_result = is_rem(op_in) ? bus.I_operandA : '1;
        end else if (overflow) begin
            special_result = is_rem(op_in) ? '0 : bus.I_operandA;
        end

        prod_fix = (sign_a_reg ^ sign_b_reg) ? -{hi_reg, lo_reg} : {hi_reg, lo_reg};
        quot_fix = (sign_a_reg ^ sign_b_reg) ? -lo_reg : lo_reg;
        rem_fix  = sign_a_reg ? -hi_reg : hi_reg;   // remainder follows dividend

        fix_result = quot_fix;
        case (op_reg)
            OP_MUL:                        fix_result = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  fix_result = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               fix_result = quot_fix;
            OP_REM, OP_REMU:               fix_result = rem_fix;
            default:                       fix_result = quot_fix;
        endcase
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        hi_next     = hi_reg;
        lo_next     = lo_reg;
        b_mag_next  = b_mag_reg;
        op_next     = op_reg;
        sign_a_next = sign_a_reg;
        sign_b_next = sign_b_reg;
        result_next = result_reg;

        if (bus.I_flush) begin
            // Flush wins over everything, including a same-cycle request.
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        op_next     = op_in;
                        sign_a_next = neg_a;
                        sign_b_next = neg_b;
                        hi_next     = '0;
                        lo_next     = a_mag;
                        b_mag_next  = b_mag;
                        cnt_next    = CNT_W'(XLEN-1);
                        if (div_zero || overflow) begin
                            result_next = special_result;
                            state_next  = ST_DONE;
                        end else begin
                            state_next  = ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    hi_next = core_hi;
                    lo_next = core_lo;
                    if (cnt_reg == '0) begin
                        state_next = ST_FIX;
                    end else begin
                        cnt_next = cnt_reg - CNT_W'(1);
                    end
                end
                ST_FIX: begin
                    result_next = fix_result;
                    state_next  = ST_DONE;
                end
                ST_DONE: begin
                    if (bus.I_out_ready) begin
                        state_next = ST_IDLE;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge I_clk) begin
        if (!I_rst_n) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            b_mag_reg  <= '0;
            op_reg     <= OP_MUL;
            sign_a_reg <= 1'b0;
            sign_b_reg <= 1'b0;
            result_reg <= '0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            hi_reg     <= hi_next;
            lo_reg     <= lo_next;
            b_mag_reg  <= b_mag_next;
            op_reg     <= op_next;
            sign_a_reg <= sign_a_next;
            sign_b_reg <= sign_b_next;
            result_reg <= result_next;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors with a scoreboard. The driver pushes the
// expected result and latency when it issues an operation; a monitor on the
// falling edge measures latency and compares results at the output handshake.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic I_clk = 1'b0;
    logic I_rst_n;

    muldiv_if #(.XLEN(32)) bus ();

    muldiv_unit #(.XLEN(32)) dut (
        .I_clk   (I_clk),
        .I_rst_n (I_rst_n),
        .bus     (bus)
    );

    always #5 I_clk = ~I_clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] res;
        int          lat;
    } exp_t;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic pending = 1'b0;
    logic prev_valid = 1'b0;
    logic ready_bad = 1'b0;
    int   since = 0;

    always @(negedge I_clk) begin
        if (!I_rst_n || bus.I_flush) begin
            pending = 1'b0;
        end else begin
            if (pending) begin
                since++;
                if (bus.O_in_ready) ready_bad = 1'b1;
            end
            if (bus.O_out_valid && !prev_valid) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got result %h with no operation expected", bus.O_result);
                end else if (since != sb_q[0].lat || ready_bad) begin
                    errors++;
                    $display("FAIL latency op=%0d: got %0d cycles (in_ready seen high while busy=%0d) expected %0d",
                             sb_q[0].op, since, ready_bad, sb_q[0].lat);
                end
            end
            if (bus.O_out_valid && bus.I_out_ready) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL result_handshake: got %h with empty scoreboard", bus.O_result);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    if (bus.O_result !== e.res) begin
                        errors++;
                        $display("FAIL result op=%0d: got %h expected %h", e.op, bus.O_result, e.res);
                    end else begin
                        $display("txn op=%0d result=%h latency=%0d", e.op, bus.O_result, since);
                    end
                end
                pending = 1'b0;
            end
            if (bus.I_in_valid && bus.O_in_ready) begin
                pending   = 1'b1;
                since     = 0;
                ready_bad = 1'b0;
            end
        end
        prev_valid = bus.O_out_valid;
    end

    // ---------------- driver ----------------
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input int lat, input bit track);
        int n = 0;
        if (track) sb_q.push_back('{op: op, res: res, lat: lat});
        bus.I_op       = op;
        bus.I_operandA = a;
        bus.I_operandB = b;
        bus.I_in_valid = 1'b1;
        while (!bus.O_in_ready && n < 200) begin
            @(posedge I_clk); #1;
            n++;
        end
        if (!bus.O_in_ready) begin
            errors++; checks++;
            $display("FAIL accept_timeout op=%0d: in_ready stayed 0 expected 1", op);
        end
        @(posedge I_clk); #1;
        bus.I_in_valid = 1'b0;
        // Operands must not matter after the accept edge.
        bus.I_operandA = 32'hDEAD_BEEF;
        bus.I_operandB = 32'h1234_5678;
        bus.I_op       = 3'b011;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!bus.O_out_valid && n < 200) begin
            @(posedge I_clk); #1;
            n++;
        end
        if (!bus.O_out_valid) begin
            errors++; checks++;
            $display("FAIL done_timeout: out_valid stayed 0 expected 1");
        end
    endtask

    task automatic complete();
        wait_valid();
        bus.I_out_ready = 1'b1;
        @(posedge I_clk); #1;
        bus.I_out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held;
        logic        rose;

        vecs.push_back('{OP_MUL,    32'd7,          32'hFFFF_FFF9, 32'hFFFF_FFCF, 34});
        vecs.push_back('{OP_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34});
        vecs.push_back('{OP_MULHU,  32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34});
        vecs.push_back('{OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 34});
        vecs.push_back('{OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34});
        vecs.push_back('{OP_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 34});
        vecs.push_back('{OP_MUL,    32'h1234_5678,  32'h0000_0010, 32'h2345_6780, 34});
        vecs.push_back('{OP_DIVU,   32'd100,        32'd7,         32'd14,        34});
        vecs.push_back('{OP_REMU,   32'd100,        32'd7,         32'd2,         34});
        vecs.push_back('{OP_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34});
        vecs.push_back('{OP_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34});
        vecs.push_back('{OP_DIVU,   32'hFFFF_FFFF,  32'd1,         32'hFFFF_FFFF, 34});
        vecs.push_back('{OP_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF, 1});
        vecs.push_back('{OP_REMU,   32'd5,          32'd0,         32'd5,         1});
        vecs.push_back('{OP_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, 1});
        vecs.push_back('{OP_REM,    32'd5,          32'd0,         32'd5,         1});
        vecs.push_back('{OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1});
        vecs.push_back('{OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 1});

        I_rst_n         = 1'b0;
        bus.I_flush     = 1'b0;
        bus.I_in_valid  = 1'b0;
        bus.I_out_ready = 1'b0;
        bus.I_op        = 3'b000;
        bus.I_operandA  = '0;
        bus.I_operandB  = '0;

        // Reset state
        repeat (3) @(posedge I_clk);
        #1;
        check("reset_in_ready",  {31'd0, bus.O_in_ready},  32'd0);
        check("reset_out_valid", {31'd0, bus.O_out_valid}, 32'd0);
        check("reset_result",    bus.O_result,             32'd0);
        I_rst_n = 1'b1;
        @(posedge I_clk); #1;
        check("post_reset_in_ready", {31'd0, bus.O_in_ready}, 32'd1);

        // Directed vectors
        foreach (vecs[i]) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat, 1'b1);
            complete();
        end

        // Back-pressure: hold out_ready low with a new request waiting
        issue(OP_MUL, 32'd3, 32'd5, 32'd15, 34, 1'b1);
        wait_valid();
        held = bus.O_result;
        sb_q.push_back('{op: OP_DIVU, res: 32'd14, lat: 34});
        bus.I_op       = OP_DIVU;
        bus.I_operandA = 32'd100;
        bus.I_operandB = 32'd7;
        bus.I_in_valid = 1'b1;
        repeat (5) begin
            @(posedge I_clk); #1;
            check("bp_out_valid", {31'd0, bus.O_out_valid}, 32'd1);
            check("bp_result",    bus.O_result,             held);
            check("bp_in_ready",  {31'd0, bus.O_in_ready},  32'd0);
        end
        bus.I_out_ready = 1'b1;
        @(posedge I_clk); #1;
        bus.I_out_ready = 1'b0;
        check("bp_idle_in_ready",  {31'd0, bus.O_in_ready},  32'd1);
        check("bp_idle_out_valid", {31'd0, bus.O_out_valid}, 32'd0);
        @(posedge I_clk); #1;
        bus.I_in_valid = 1'b0;
        check("bp_next_accepted", {31'd0, bus.O_in_ready}, 32'd0);
        complete();

        // Request together with flush in IDLE is ignored
        bus.I_op       = OP_MUL;
        bus.I_operandA = 32'd2;
        bus.I_operandB = 32'd2;
        bus.I_in_valid = 1'b1;
        bus.I_flush    = 1'b1;
        @(posedge I_clk); #1;
        bus.I_in_valid = 1'b0;
        bus.I_flush    = 1'b0;
        check("flush_blocks_accept", {31'd0, bus.O_in_ready}, 32'd1);

        // Flush at CALC cycle 10
        issue(OP_DIVU, 32'd1000, 32'd3, 32'd0, 0, 1'b0);
        repeat (9) @(posedge I_clk);
        #1;
        bus.I_flush = 1'b1;
        @(posedge I_clk); #1;
        bus.I_flush = 1'b0;
        check("flush_idle_in_ready",  {31'd0, bus.O_in_ready},  32'd1);
        check("flush_idle_out_valid", {31'd0, bus.O_out_valid}, 32'd0);
        rose = 1'b0;
        repeat (40) begin
            @(posedge I_clk); #1;
            if (bus.O_out_valid) rose = 1'b1;
        end
        check("flush_no_output", {31'd0, rose}, 32'd0);
        issue(OP_DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 34, 1'b1);
        complete();

        // Reset in the middle of CALC
        issue(OP_MUL, 32'd9, 32'd9, 32'd0, 0, 1'b0);
        repeat (5) @(posedge I_clk);
        #1;
        I_rst_n = 1'b0;
        @(posedge I_clk); #1;
        check("rst_mid_in_ready",  {31'd0, bus.O_in_ready},  32'd0);
        check("rst_mid_out_valid", {31'd0, bus.O_out_valid}, 32'd0);
        check("rst_mid_result",    bus.O_result,             32'd0);
        I_rst_n = 1'b1;
        @(posedge I_clk); #1;
        check("rst_release_in_ready",  {31'd0, bus.O_in_ready},  32'd1);
        check("rst_release_out_valid", {31'd0, bus.O_out_valid}, 32'd0);
        check("rst_release_result",    bus.O_result,             32'd0);
        issue(OP_REMU, 32'd1000, 32'd7, 32'd6, 34, 1'b1);
        complete();

        repeat (3) @(posedge I_clk);
        #1;
        check("scoreboard_empty", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative, parametrised multiply/divide unit implementing the RV32M/RV64M operation set beside the single-cycle integer ALU in the execute stage. It accepts one operation through a valid/ready handshake, computes it over XLEN+2 cycles with a radix-2 shift-add or restoring-divide datapath, and presents the result through a second valid/ready handshake. Divide-by-zero and signed overflow are resolved in one cycle. A flush input abandons the operation in flight.

## Interface
- XLEN, 32, operand/result width; legal values 32 or 64
- I_clk  input  1  rising-edge clock
- I_rst_n  input  1  synchronous active-low reset
- I_flush  input  1  abandon any operation; highest priority after reset
- I_in_valid  input  1  operation request
- O_in_ready  output  1  unit can accept; high only in IDLE and when I_rst_n=1
- I_op  input  3  funct3 code: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- I_operandA  input  XLEN  rs1 (multiplicand / dividend)
- I_operandB  input  XLEN  rs2 (multiplier / divisor)
- O_out_valid  output  1  O_result holds a completed result
- I_out_ready  input  1  consumer takes result
- O_result  output  XLEN  result, registered

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE: O_in_ready=1. Accept on I_in_valid&O_in_ready. Latch op, operand magnitudes and sign flags.
  - Signed operands are DIV, REM, A and B of MULH, and A of MULHSU. Negate to magnitude if MSB is set.
  - Load counter with XLEN-1.
- Special cases go IDLE->DONE directly, with the result computed from raw operands:
  - Division by zero: DIV/DIVU give all ones; REM/REMU give operandA.
  - Signed overflow (DIV/REM, A=1<<(XLEN-1), B=all ones): DIV gives operandA; REM gives 0.
- CALC: one iteration per cycle, XLEN iterations total. Leave when the counter is 0.
  - Multiply: 2*XLEN-bit product, unsigned shift-add on magnitudes.
  - Divide: restoring divide. Shift {rem,quot} left, try subtract. Quotient bit = subtract did not borrow.
- FIX: one cycle.
  - Negate the 2*XLEN product if the operand signs differ (signed ops only).
  - Negate the quotient if the signs differ (DIV).
  - Give the remainder the dividend's sign (REM).
  - Select: MUL takes product[XLEN-1:0]; MULH* take product[2XLEN-1:XLEN]; DIV*/REM* take the quotient or remainder. Register the selection into O_result.
- DONE: O_out_valid=1, O_result held stable. On I_out_ready go to IDLE.
- I_flush in any state: next state IDLE and O_out_valid=0. O_result keeps its last value. An input handshake in the same cycle as I_flush is ignored.
- Reset (I_rst_n=0 at an edge): state IDLE, counter 0, O_out_valid=0, O_result=0. O_in_ready is 0 while reset is asserted.

## Timing
- Accept edge = cycle 0.
- Normal ops: CALC during cycles 1..XLEN, FIX at cycle XLEN+1, O_out_valid high from cycle XLEN+2. That is 34 for XLEN=32.
- Special cases: O_out_valid high from cycle 1.
- Throughput: the unit does not accept in the result-handoff cycle. The next accept is the cycle after the output handshake, so there is at least one IDLE cycle between ops.
- O_in_ready depends only on state and I_rst_n, with no combinational path from I_in_valid. O_out_valid depends only on state.
- Back-pressure in DONE is unbounded. O_result and O_out_valid do not change until the handshake, flush or reset.
- Operands are sampled only at the accept edge. Changes on the inputs afterwards have no effect.

## Structure
- Package muldiv_pkg holds:
  - op_t, a 3-bit enum of the eight funct3 codes
  - state_t for IDLE/CALC/FIX/DONE
  - helper functions is_div(op), is_signed_a(op), is_signed_b(op)
- Sub-module muldiv_iter_core holds the per-cycle shift-add / trial-subtract step, parametrised by XLEN. It contains no state.
- muldiv_unit holds the FSM, counter, magnitude and sign registers, and output register.

## Test plan
- MUL 7 * 0xFFFFFFF9 (-7):
  - result 0xFFFFFFCF
  - O_out_valid rises exactly 34 cycles after accept
  - O_in_ready=0 throughout
- MULH 0x80000000 * 0x80000000 -> 0x40000000; MULHU same operands -> 0x40000000; MULHSU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFF.
- DIVU 100/7 -> 14 and REMU -> 2; DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD and REM -> 0xFFFFFFFF.
- Special cases, each with O_out_valid at cycle 1:
  - DIV 5/0 -> 0xFFFFFFFF
  - REMU 5/0 -> 5
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000
  - REM of the same operands -> 0
- Hold I_out_ready low for 5 cycles after O_out_valid:
  - result and O_out_valid stay stable
  - a new I_in_valid is not accepted
  - after the handshake, IDLE lasts 1 cycle, then the next op is accepted
- Flush and reset mid-operation:
  - I_flush at CALC cycle 10 -> IDLE next cycle, O_out_valid never rises, the next op completes correctly.
  - I_rst_n low in CALC -> O_result=0, O_out_valid=0, O_in_ready=1 the cycle after release.
